rs232_rx_ctrl: RTL and testbench

//  Drain controller for the rs232 receiver, which holds one character only.

---
 rtl/rs232_rx_ctrl.sv | 111 +++++++++++
 tb/tb_rs232_rx_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx_ctrl.sv
// rs232 receiver drain controller.
// Captures each held character into a FWFT FIFO and records overruns.
module rs232_rx_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          Ph0,
  input  logic          Reset_n,
  input  logic          rcvReady,
  input  logic [7:0]    rcvData,
  output logic          readSR,
  output logic          rdValid,
  output logic [7:0]    rdData,
  input  logic          rdPop,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          clrOverrun,
  output logic [7:0]    dropCount
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t      r_state;
  state_t      w_next;
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic [7:0]  r_mem [DEPTH];
  logic        r_ovr;
  logic [7:0]  r_drops;
  logic        w_cap;
  logic        w_pop;
  logic        w_accept;
  logic        w_push;
  logic        w_drop;

  // Pointers carry one extra wrap bit so full and empty differ.
  assign count     = r_wr - r_rd;
  assign rdValid   = (count != '0);
  assign rdData    = r_mem[r_rd[AW-1:0]];
  assign readSR    = (r_state == ACK);
  assign overrun   = r_ovr;
  assign dropCount = r_drops;

  assign w_pop    = rdPop & rdValid;
  assign w_accept = (count < FULL) | w_pop;
  assign w_push   = w_cap & w_accept;
  assign w_drop   = w_cap & ~w_accept;

  // Next-state: one capture per ready, then wait for ready to fall.
  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (rcvReady) begin
          w_cap  = 1'b1;
          w_next = ACK;
        end
      end
      ACK:  w_next = WAIT;
      WAIT: begin
        if (!rcvReady) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Ph0 or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // FIFO pointers.
  always_ff @(posedge Ph0 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge Ph0) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= rcvData;
  end

  // Overrun tracking; a drop beats a simultaneous clear.
  always_ff @(posedge Ph0 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ovr   <= 1'b0;
      r_drops <= '0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
      if (clrOverrun)          r_drops <= 8'd1;
      else if (r_drops != '1)  r_drops <= r_drops + 1'b1;
    end else if (clrOverrun) begin
      r_ovr   <= 1'b0;
      r_drops <= '0;
    end
  end

endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// Directed bench for rs232_rx_ctrl.
// Receiver model drops ready a set number of cycles after readSR.
module tb_rs232_rx_ctrl;

  logic       Ph0 = 1'b0;
  logic       Reset_n;
  logic       rcvReady;
  logic [7:0] rcvData;
  logic       readSR;
  logic       rdValid;
  logic [7:0] rdData;
  logic       rdPop;
  logic [4:0] count;
  logic       overrun;
  logic       clrOverrun;
  logic [7:0] dropCount;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  rs232_rx_ctrl #(.DEPTH(16), .AW(4)) dut (
    .Ph0(Ph0),
    .Reset_n(Reset_n),
    .rcvReady(rcvReady),
    .rcvData(rcvData),
    .readSR(readSR),
    .rdValid(rdValid),
    .rdData(rdData),
    .rdPop(rdPop),
    .count(count),
    .overrun(overrun),
    .clrOverrun(clrOverrun),
    .dropCount(dropCount)
  );

  always #5 Ph0 = ~Ph0;

  always @(negedge Ph0) begin
    if (readSR) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Ph0);
    #1;
  endtask

  task automatic do_reset();
    Reset_n    = 1'b0;
    rcvReady   = 1'b0;
    rcvData    = 8'h00;
    rdPop      = 1'b0;
    clrOverrun = 1'b0;
    repeat (2) tick();
    Reset_n = 1'b1;
    tick();
  endtask

  // One character: ready seen now (IDLE), readSR in next cycle,
  // ready held 'hold' extra cycles, then FSM returns to IDLE.
  task automatic send(input logic [7:0] d, input int hold,
                      input logic pop, input logic clr);
    rcvReady   = 1'b1;
    rcvData    = d;
    rdPop      = pop;
    clrOverrun = clr;
    tick();
    rdPop      = 1'b0;
    clrOverrun = 1'b0;
    rcvData    = 8'hxx;
    chk("readSR_pulse", readSR, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("readSR_wait", readSR, 0);
    end
    tick();
    rcvReady = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input logic [7:0] exp);
    chk("pop_valid", rdValid, 1);
    chk("pop_data", rdData, exp);
    rdPop = 1'b1;
    tick();
    rdPop = 1'b0;
  endtask

  initial begin
    int p0;

    do_reset();
    chk("rst_count", count, 0);
    chk("rst_valid", rdValid, 0);
    chk("rst_readSR", readSR, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_drops", dropCount, 0);

    // Single character.
    p0 = pulses;
    send(8'h41, 0, 1'b0, 1'b0);
    chk("t1_pulses", pulses - p0, 1);
    chk("t1_valid", rdValid, 1);
    chk("t1_data", rdData, 8'h41);
    chk("t1_count", count, 1);

    // Long-held ready gives one capture only.
    do_reset();
    p0 = pulses;
    send(8'h42, 5, 1'b0, 1'b0);
    repeat (2) tick();
    chk("t2_pulses", pulses - p0, 1);
    chk("t2_count", count, 1);
    chk("t2_data", rdData, 8'h42);

    // Fill, overflow by one, drain in order.
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), 0, 1'b0, 1'b0);
    chk("t3_full", count, 16);
    chk("t3_ovr0", overrun, 0);
    p0 = pulses;
    send(8'h10, 0, 1'b0, 1'b0);
    chk("t3_droppulse", pulses - p0, 1);
    chk("t3_count", count, 16);
    chk("t3_ovr", overrun, 1);
    chk("t3_drops", dropCount, 1);
    for (int i = 0; i < 16; i++) pop_chk(8'(i));
    chk("t3_empty", count, 0);
    chk("t3_evalid", rdValid, 0);
    rdPop = 1'b1;
    tick();
    rdPop = 1'b0;
    chk("t3_underflow", count, 0);

    // Pop and push together on a full FIFO.
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), 0, 1'b0, 1'b0);
    send(8'h55, 0, 1'b1, 1'b0);
    chk("t4_count", count, 16);
    chk("t4_ovr", overrun, 0);
    for (int i = 1; i < 16; i++) pop_chk(8'(i));
    pop_chk(8'h55);
    chk("t4_empty", count, 0);

    // Saturating drop count, then clear.
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), 0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) send(8'hAA, 0, 1'b0, 1'b0);
    chk("t5_sat", dropCount, 255);
    chk("t5_ovr", overrun, 1);
    clrOverrun = 1'b1;
    tick();
    clrOverrun = 1'b0;
    chk("t5_clr_drops", dropCount, 0);
    chk("t5_clr_ovr", overrun, 0);
    chk("t5_count", count, 16);

    // Clear in the same cycle as a drop.
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), 0, 1'b0, 1'b0);
    send(8'hAA, 0, 1'b0, 1'b0);
    send(8'hAB, 0, 1'b0, 1'b0);
    chk("t5b_pre", dropCount, 2);
    send(8'hAC, 0, 1'b0, 1'b1);
    chk("t5b_ovr", overrun, 1);
    chk("t5b_drops", dropCount, 1);

    // Reset during ACK; held character is captured again.
    do_reset();
    rcvReady = 1'b1;
    rcvData  = 8'h7E;
    tick();
    chk("t6_ack", readSR, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("t6_fall", readSR, 0);
    chk("t6_count", count, 0);
    tick();
    tick();
    Reset_n = 1'b1;
    chk("t6_rst_valid", rdValid, 0);
    tick();
    chk("t6_reack", readSR, 1);
    rcvReady = 1'b0;
    tick();
    tick();
    chk("t6_recount", count, 1);
    chk("t6_data", rdData, 8'h7E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
